led_pwm_fader: RTL

Per-LED brightness fader and PWM driver between the pattern logic in `top` and the `led[3:0]` board pins. It accepts 4-bit on/off patterns over a valid/ready handshake. It ramps each LED's 8-bit brightness linearly toward full-on or full-off, and drives the pins with a PWM signal at the 100 MHz system clock.

---
 rtl/led_pwm_fader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED brightness fader and PWM pin driver.
//
// Accepts 4-bit on/off patterns over a valid/ready handshake. While fading,
// each LED's 8-bit level ramps by STEP once every PRESCALE clocks toward full-on
// (255) or full-off (0), saturating at both ends. The pins are driven by a
// free-running 8-bit PWM counter compared against each LED's duty value.
//
// Build option: define LED_GAMMA_EN to map level to duty through a square-law
// curve (duty = level*level >> 8, with level 255 forced to duty 255). Without
// it, duty equals level. Handshake and fade timing are the same in both builds.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   pat_valid  pat_data is offered
//   pat_ready  fader can accept a pattern (IDLE only)
//   pat_data   target pattern; bit i=1 fades LED i to full-on
//   busy       fade in progress
//   led        registered PWM outputs

module led_pwm_fader #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned STEP     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pat_valid,
  output logic       pat_ready,
  input  logic [3:0] pat_data,
  output logic       busy,
  output logic [3:0] led
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);
  localparam logic [8:0] Step9 = 9'(STEP);

  typedef enum logic [0:0] {StIdle, StFade} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    pwm_cnt_q;
  logic [3:0]    target_q;  // 1 = ramp to 255, 0 = ramp to 0
  logic [7:0]    level_q [4];

  logic [7:0]    level_step [4];
  logic [8:0]    level_sum  [4];
  logic [15:0]   level_sq   [4];
  logic [7:0]    duty       [4];
  logic          tick;
  logic          accept;
  logic          all_done;

  assign tick   = (presc_q == PrescMax);
  assign accept = pat_valid && pat_ready;

  // Saturating one-step move of every level toward its target.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      level_step[i] = level_q[i];
      level_sum[i]  = {1'b0, level_q[i]} + Step9;
      if (target_q[i]) begin
        level_step[i] = (level_sum[i] >= 9'd255) ? 8'hff : level_sum[i][7:0];
      end else begin
        level_step[i] = ({1'b0, level_q[i]} < Step9) ? 8'h00 : (level_q[i] - Step9[7:0]);
      end
      if (level_step[i] != {8{target_q[i]}}) all_done = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level_sq[i] = level_q[i] * level_q[i];
`ifdef LED_GAMMA_EN
      duty[i] = (level_q[i] == 8'hff) ? 8'hff : level_sq[i][15:8];
`else
      duty[i] = level_q[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      pwm_cnt_q <= 8'h00;
      target_q  <= 4'b0000;
      pat_ready <= 1'b0;
      busy      <= 1'b0;
      led       <= 4'b0000;
      for (int i = 0; i < 4; i++) level_q[i] <= 8'h00;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      // Duty 255 must be solid on; the strict compare alone would drop one clock.
      for (int i = 0; i < 4; i++) begin
        led[i] <= (duty[i] == 8'hff) || (duty[i] > pwm_cnt_q);
      end

      if (accept || tick) presc_q <= '0;
      else                presc_q <= presc_q + PW'(1);

      unique case (state_q)
        StIdle: begin
          pat_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            target_q  <= pat_data;
            state_q   <= StFade;
            pat_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        StFade: begin
          if (tick) begin
            for (int i = 0; i < 4; i++) level_q[i] <= level_step[i];
            if (all_done) begin
              state_q   <= StIdle;
              pat_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
